// File: rtl/pipe_stall_ctrl.sv
// Hazard controller for the in-order pipeline. It resolves per-stage stall requests and
// redirect (flush) requests into per-stage hold/bubble controls. Redirects that a stall
// blocks are parked in a one-entry pending slot and replayed later. The block also keeps
// saturating stall/flush counters and a sticky stall watchdog.
module pipe_stall_ctrl #(
  parameter int unsigned NSTAGE     = 5,
  parameter int unsigned STG_W      = (NSTAGE > 1) ? $clog2(NSTAGE) : 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              flush_req,
  input  logic [STG_W-1:0]  flush_stage,
  output logic              hold_pc,
  output logic [NSTAGE-1:0] hold,
  output logic [NSTAGE-1:0] bubble,
  output logic              flush_go,
  output logic [STG_W-1:0]  flush_go_stage,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
  output logic              wdog_trip
);

  localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WdLimit = WD_W'(WDOG_LIMIT);
  localparam logic [STG_W:0] NStageV = (STG_W + 1)'(NSTAGE);

  // Action taken this cycle, highest-priority condition first.
  typedef enum logic [2:0] {
    ActIdle,
    ActRst,
    ActFreeze,
    ActFlush,
    ActStall
  } act_e;

  act_e act;

  logic             pend_v_q, pend_v_d;
  logic [STG_W-1:0] pend_stage_q, pend_stage_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             trip_q, trip_d;

  logic             new_ok;
  logic             fv;
  logic [STG_W-1:0] fs;
  logic             stall_any;
  logic [STG_W-1:0] s_idx;
  logic             stall_blocks;

  // Decode the flush candidate, the oldest stalling stage and the winning action.
  always_comb begin
    // Stage 0 cannot redirect and indices past WB do not exist.
    new_ok = flush_req && (flush_stage != '0) && ({1'b0, flush_stage} < NStageV);
    fv     = new_ok | pend_v_q;
    fs     = '0;
    if (pend_v_q) fs = pend_stage_q;
    // The older (higher-index) redirect wins when both are present.
    if (new_ok && (flush_stage > fs)) fs = flush_stage;

    stall_any = |stall_req;
    s_idx     = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stall_req[i]) s_idx = STG_W'(i);
    end
    // Only a stall at or beyond the redirecting stage blocks it; younger ones are wrong-path.
    stall_blocks = stall_any && (s_idx >= fs);

    if (rst) begin
      act = ActRst;
    end else if (!rdy) begin
      act = ActFreeze;
    end else if (fv && !stall_blocks) begin
      act = ActFlush;
    end else if (stall_any) begin
      act = ActStall;
    end else begin
      act = ActIdle;
    end
  end

  // Per-stage hold/bubble and PC controls for the chosen action.
  always_comb begin
    hold_pc        = 1'b0;
    hold           = '0;
    bubble         = '0;
    flush_go       = 1'b0;
    flush_go_stage = '0;
    unique case (act)
      ActFreeze: begin
        hold_pc = 1'b1;
        hold    = '1;
      end
      ActFlush: begin
        flush_go       = 1'b1;
        flush_go_stage = fs;
        for (int i = 0; i < NSTAGE; i++) begin
          bubble[i] = (STG_W'(i) < fs);
        end
      end
      ActStall: begin
        hold_pc = 1'b1;
        for (int i = 0; i < NSTAGE; i++) begin
          hold[i]   = (STG_W'(i) < s_idx);
          bubble[i] = (STG_W'(i) == s_idx);
        end
      end
      default: ;
    endcase
  end

  // Next-state for the pending redirect, counters and watchdog.
  always_comb begin
    pend_v_d     = pend_v_q;
    pend_stage_d = pend_stage_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    trip_d       = trip_q;
    unique case (act)
      ActRst: begin
        pend_v_d     = 1'b0;
        pend_stage_d = '0;
        stall_cnt_d  = '0;
        flush_cnt_d  = '0;
        wd_cnt_d     = '0;
        trip_d       = 1'b0;
      end
      ActFreeze: begin
        // Counters freeze, but a redirect arriving now must not be lost.
        if (new_ok) begin
          pend_v_d     = 1'b1;
          pend_stage_d = fs;
        end
      end
      ActFlush: begin
        pend_v_d = 1'b0;
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        wd_cnt_d = '0;
      end
      ActStall: begin
        if (fv) begin
          pend_v_d     = 1'b1;
          pend_stage_d = fs;
        end
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (wd_cnt_q != WdLimit) wd_cnt_d = wd_cnt_q + WD_W'(1);
        if (wd_cnt_d == WdLimit) trip_d = 1'b1;
      end
      default: begin
        wd_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge clk) begin
    pend_v_q     <= pend_v_d;
    pend_stage_q <= pend_stage_d;
    stall_cnt_q  <= stall_cnt_d;
    flush_cnt_q  <= flush_cnt_d;
    wd_cnt_q     <= wd_cnt_d;
    trip_q       <= trip_d;
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign wdog_trip    = trip_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model of the controller.
module tb_pipe_stall_ctrl;

  localparam int N  = 5;
  localparam int SW = 3;
  localparam int WD = 4;

  logic          clk;
  logic          rst;
  logic          rdy;
  logic [N-1:0]  stall_req;
  logic          flush_req;
  logic [SW-1:0] flush_stage;

  logic          hold_pc, flush_go, wdog_trip;
  logic [N-1:0]  hold, bubble;
  logic [SW-1:0] flush_go_stage;
  logic [15:0]   stall_cycles, flush_count;

  logic          hold_pc2, flush_go2, wdog_trip2;
  logic [N-1:0]  hold2, bubble2;
  logic [SW-1:0] flush_go_stage2;
  logic [1:0]    stall_cycles2, flush_count2;

  pipe_stall_ctrl #(.NSTAGE(N), .STG_W(SW), .CNT_W(16), .WDOG_LIMIT(WD)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .flush_req(flush_req),
    .flush_stage(flush_stage), .hold_pc(hold_pc), .hold(hold), .bubble(bubble),
    .flush_go(flush_go), .flush_go_stage(flush_go_stage), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .wdog_trip(wdog_trip)
  );

  pipe_stall_ctrl #(.NSTAGE(N), .STG_W(SW), .CNT_W(2), .WDOG_LIMIT(WD)) dut2 (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .flush_req(flush_req),
    .flush_stage(flush_stage), .hold_pc(hold_pc2), .hold(hold2), .bubble(bubble2),
    .flush_go(flush_go2), .flush_go_stage(flush_go_stage2), .stall_cycles(stall_cycles2),
    .flush_count(flush_count2), .wdog_trip(wdog_trip2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: pending redirect, unbounded event counts, current stall run length.
  bit     m_pv = 0;
  int     m_ps = 0;
  longint m_sc = 0;
  longint m_fc = 0;
  int     m_run = 0;
  bit     m_trip = 0;

  int           e_kind;  // 0 idle, 1 reset, 2 freeze, 3 flush, 4 stall
  int           e_fs;
  bit           e_legal, e_fv;
  logic         e_hold_pc, e_go;
  logic [N-1:0] e_hold, e_bubble;

  function automatic void calc();
    int s;
    s = -1;
    for (int i = 0; i < N; i++) if (stall_req[i]) s = i;
    e_legal = flush_req && (int'(flush_stage) >= 1) && (int'(flush_stage) < N);
    e_fs = m_pv ? m_ps : 0;
    if (e_legal && int'(flush_stage) > e_fs) e_fs = int'(flush_stage);
    e_fv = e_legal || m_pv;
    e_hold_pc = 1'b0;
    e_hold    = '0;
    e_bubble  = '0;
    e_go      = 1'b0;
    if (rst) e_kind = 1;
    else if (!rdy) begin
      e_kind = 2; e_hold_pc = 1'b1; e_hold = '1;
    end else if (e_fv && s < e_fs) begin
      e_kind = 3; e_go = 1'b1; e_bubble = N'((1 << e_fs) - 1);
    end else if (s >= 0) begin
      e_kind = 4; e_hold_pc = 1'b1; e_hold = N'((1 << s) - 1); e_bubble = N'(1 << s);
    end else e_kind = 0;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    calc();
    chk("hold_pc", 32'(hold_pc), 32'(e_hold_pc));
    chk("hold", 32'(hold), 32'(e_hold));
    chk("bubble", 32'(bubble), 32'(e_bubble));
    chk("flush_go", 32'(flush_go), 32'(e_go));
    if (e_go) chk("flush_go_stage", 32'(flush_go_stage), 32'(e_fs));
    chk("hold2", 32'(hold2), 32'(e_hold));
    chk("bubble2", 32'(bubble2), 32'(e_bubble));
    chk("stall_cycles", 32'(stall_cycles), 32'(sat(m_sc, 65535)));
    chk("flush_count", 32'(flush_count), 32'(sat(m_fc, 65535)));
    chk("stall_cycles2", 32'(stall_cycles2), 32'(sat(m_sc, 3)));
    chk("flush_count2", 32'(flush_count2), 32'(sat(m_fc, 3)));
    chk("wdog_trip", 32'(wdog_trip), 32'(m_trip));
    chk("wdog_trip2", 32'(wdog_trip2), 32'(m_trip));
  end

  // Model update at the active edge.
  always @(posedge clk) begin
    calc();
    case (e_kind)
      1: begin
        m_pv <= 0; m_ps <= 0; m_sc <= 0; m_fc <= 0; m_run <= 0; m_trip <= 0;
      end
      2: if (e_legal) begin
        m_pv <= 1; m_ps <= e_fs;
      end
      3: begin
        m_pv <= 0; m_fc <= m_fc + 1; m_run <= 0;
      end
      4: begin
        if (e_fv) begin
          m_pv <= 1; m_ps <= e_fs;
        end
        m_sc  <= m_sc + 1;
        m_run <= (m_run + 1 > WD) ? WD : m_run + 1;
        if (m_run + 1 >= WD) m_trip <= 1;
      end
      default: m_run <= 0;
    endcase
  end

  task automatic drive(input logic r, input logic y, input logic [N-1:0] st, input logic fq,
                       input logic [SW-1:0] fsg);
    rst = r; rdy = y; stall_req = st; flush_req = fq; flush_stage = fsg;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b1, 5'b11111, 1'b1, 3'd2);
    to_neg();
    chk("rst_hold", 32'(hold), 32'h0);
    chk("rst_bubble", 32'(bubble), 32'h0);
    chk("rst_hold_pc", 32'(hold_pc), 32'h0);
    chk("rst_flush_go", 32'(flush_go), 32'h0);
    next();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    chk("rst_stall_cycles", 32'(stall_cycles), 32'h0);
    chk("rst_flush_count", 32'(flush_count), 32'h0);
    chk("rst_trip", 32'(wdog_trip), 32'h0);

    // Priority stall: oldest stalling stage is 3.
    drive(1'b0, 1'b1, 5'b01010, 1'b0, '0);
    to_neg();
    chk("prio_hold", 32'(hold), 32'(5'b00111));
    chk("prio_bubble", 32'(bubble), 32'(5'b01000));
    chk("prio_hold_pc", 32'(hold_pc), 32'h1);
    next();
    chk("prio_stall_cycles", 32'(stall_cycles), 32'h1);

    // Unblocked flush: stage-0 stall is wrong-path.
    drive(1'b0, 1'b1, 5'b00001, 1'b1, 3'd2);
    to_neg();
    chk("uflush_bubble", 32'(bubble), 32'(5'b00011));
    chk("uflush_hold", 32'(hold), 32'h0);
    chk("uflush_go", 32'(flush_go), 32'h1);
    chk("uflush_stage", 32'(flush_go_stage), 32'h2);
    next();
    chk("uflush_count", 32'(flush_count), 32'h1);

    // Blocked flush at stage 2, merged with stage 3, replayed once the stall drops.
    drive(1'b0, 1'b1, 5'b01000, 1'b1, 3'd2);
    to_neg();
    chk("blk_go_c1", 32'(flush_go), 32'h0);
    chk("blk_hold_c1", 32'(hold), 32'(5'b00111));
    next();
    drive(1'b0, 1'b1, 5'b01000, 1'b1, 3'd3);
    to_neg();
    chk("blk_go_c2", 32'(flush_go), 32'h0);
    next();
    drive(1'b0, 1'b1, 5'b01000, 1'b0, '0);
    to_neg();
    chk("blk_go_c3", 32'(flush_go), 32'h0);
    next();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    to_neg();
    chk("merge_go", 32'(flush_go), 32'h1);
    chk("merge_stage", 32'(flush_go_stage), 32'h3);
    chk("merge_bubble", 32'(bubble), 32'(5'b00111));
    next();
    chk("merge_count", 32'(flush_count), 32'h2);
    chk("merge_stall_cycles", 32'(stall_cycles), 32'h4);
    chk("merge_stall_cycles2", 32'(stall_cycles2), 32'h3);
    to_neg();
    chk("merge_single_pulse", 32'(flush_go), 32'h0);
    next();

    // Freeze with a redirect pulse, then apply it on the first ready cycle.
    drive(1'b0, 1'b0, 5'b00100, 1'b1, 3'd1);
    to_neg();
    chk("frz_hold", 32'(hold), 32'(5'b11111));
    chk("frz_hold_pc", 32'(hold_pc), 32'h1);
    chk("frz_bubble", 32'(bubble), 32'h0);
    chk("frz_go", 32'(flush_go), 32'h0);
    next();
    chk("frz_stall_cycles", 32'(stall_cycles), 32'h4);
    chk("frz_flush_count", 32'(flush_count), 32'h2);
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    to_neg();
    chk("frz_replay_go", 32'(flush_go), 32'h1);
    chk("frz_replay_stage", 32'(flush_go_stage), 32'h1);
    chk("frz_replay_bubble", 32'(bubble), 32'(5'b00001));
    next();
    chk("frz_replay_count", 32'(flush_count), 32'h3);

    // Illegal redirect stages are ignored.
    drive(1'b0, 1'b1, '0, 1'b1, 3'd0);
    to_neg();
    chk("ill0_go", 32'(flush_go), 32'h0);
    chk("ill0_bubble", 32'(bubble), 32'h0);
    next();
    drive(1'b0, 1'b1, '0, 1'b1, 3'd6);
    to_neg();
    chk("ill6_go", 32'(flush_go), 32'h0);
    next();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    to_neg();
    chk("ill_no_pending", 32'(flush_go), 32'h0);
    next();
    chk("ill_count", 32'(flush_count), 32'h3);

    // Watchdog trips on the edge ending the 4th consecutive stall cycle.
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b1, 5'b00010, 1'b0, '0);
      to_neg();
      chk("wd_before", 32'(wdog_trip), 32'h0);
      next();
      chk("wd_after", 32'(wdog_trip), (c == 4) ? 32'h1 : 32'h0);
    end
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    next();
    chk("wd_sticky", 32'(wdog_trip), 32'h1);
    chk("wd_stall_cycles", 32'(stall_cycles), 32'h8);
    chk("sat_stall_cycles2", 32'(stall_cycles2), 32'h3);
    drive(1'b1, 1'b1, 5'b00010, 1'b0, '0);
    next();
    drive(1'b0, 1'b1, '0, 1'b0, '0);
    chk("wd_rst_clear", 32'(wdog_trip), 32'h0);
    chk("wd_rst_stall_cycles", 32'(stall_cycles), 32'h0);

    // Random phase, checked every cycle by the compare process.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] st;
      st = ($urandom_range(1, 0) == 0) ? '0 : N'($urandom);
      drive(($urandom_range(99, 0) == 0), ($urandom_range(7, 0) != 0), st,
            ($urandom_range(3, 0) == 0), SW'($urandom));
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
